mpi_dma_arb: RTL and testbench
==============================

MPI_DMA_ARB -- requirements
Module: mpi_dma_arb

Interface
REQ-001 Parameter GRANT_TMO, default 8'd200: maximum bus-ownership cycles per grant before forced release.
REQ-002 pin_clk  input  1  processor-domain clock; all state on posedge.
REQ-003 pin_dclo_n  input  1  asynchronous active-low reset.
REQ-004 pin_req_n  input  4  per-device DMA request, active low, asynchronous to pin_clk.
REQ-005 pin_gnt_n  output  4  per-device bus-ownership grant, active low, at most one low.
REQ-006 pin_dmr_n  output  1  bus request to CPU, active low.
REQ-007 pin_dmgi_n  input  1  bus grant from CPU, active low.
REQ-008 pin_dmgo_n  output  1  grant passed downstream, active low.
REQ-009 pin_sack_n  output  1  bus acknowledge, active low.
REQ-010 pin_sync_n, pin_rply_n  input  1 each  bus strobes, used for bus-idle detection.
REQ-011 pin_tmo  output  1  one-cycle pulse on forced release.

Function
REQ-012 pin_req_n SHALL pass through a 2-flop synchronizer; "req" below means the synchronized value.
REQ-013 States SHALL be IDLE, REQ, ACK, WAIT_BUS, OWN, REL.
REQ-014 IDLE: any unmasked req active -> REQ next cycle; pin_dmr_n low while in REQ.
REQ-015 REQ: all unmasked reqs inactive -> IDLE, pin_dmr_n high next cycle; this check SHALL take precedence over a simultaneous pin_dmgi_n low.
REQ-016 REQ with pin_dmgi_n low -> ACK: winner latched, pin_sack_n low, pin_dmr_n high.
REQ-017 ACK SHALL last exactly one cycle, then WAIT_BUS.
REQ-018 WAIT_BUS: pin_sync_n and pin_rply_n both sampled high -> OWN, pin_gnt_n[winner] low, hold counter cleared to 0.
REQ-019 OWN: counter increments each cycle; winner req inactive -> REL; counter == GRANT_TMO-1 with req still active -> REL plus pin_tmo pulse; release SHALL win if both occur together.
REQ-020 REL: all pin_gnt_n high, pin_sack_n still low for this one cycle; then IDLE with pin_sack_n high.
REQ-021 A timed-out requester SHALL be masked from arbitration until its req is seen inactive.
REQ-022 pin_dmgo_n SHALL equal pin_dmgi_n combinationally only in IDLE, and be high in every other state.
REQ-023 Winner selection SHALL be fixed priority, index 0 highest, unless REQ-029 applies.
REQ-024 Invariant: pin_dmr_n low and pin_sack_n low SHALL never coincide; at most one pin_gnt_n low.
REQ-025 Request-to-pin_dmr_n latency SHALL be 3 cycles: 2 synchronizer + 1 state.

Reset
REQ-026 pin_dclo_n low SHALL immediately force state IDLE, all outputs high except pin_tmo low, counter 0, mask 0, synchronizers inactive, RR pointer 0.
REQ-027 Reset mid-grant SHALL release pin_gnt_n and pin_sack_n asynchronously, with no pin_tmo pulse.

Configuration
REQ-028 Macro MPI_DMA_ARB_RR_EN selects the arbitration policy.
REQ-029 Defined: round-robin; search starts at (last winner + 1) mod 4; pointer updates on entry to ACK. Undefined: fixed priority per REQ-023, no pointer logic.

Verification
REQ-030 req_n=4'b1110, dmgi_n low 2 cycles after dmr_n low, bus idle: dmr_n low at cycle 3; sack_n low; gnt_n=4'b1110 two cycles after dmgi_n low; release -> gnt_n=4'b1111, sack_n high 2 cycles later.
REQ-031 req_n=4'b0000 held, four grants in sequence: fixed priority grants index 0 every time; RR_EN grants 0,1,2,3.
REQ-032 In WAIT_BUS, hold sync_n low 10 cycles: gnt_n stays 4'b1111 until sync_n and rply_n high, then the winner grant goes low the next cycle.
REQ-033 GRANT_TMO=8'd16, holder never releases: gnt high after 16 OWN cycles; one-cycle pin_tmo; requester not re-granted until req_n goes high.
REQ-034 No request, dmgi_n toggled: dmgo_n follows it; dclo_n low during OWN -> gnt_n=4'b1111 and sack_n high without a clock edge.

Source files
------------

// File: rtl/mpi_dma_arb_if.sv
// Bus-side signal bundle for the MPI DMA arbiter: device requests/grants,
// CPU DMR/DMGI/DMGO daisy chain, SACK and the bus strobes used for idle detection.
interface mpi_dma_arb_if;
  logic [3:0] pin_req_n;
  logic [3:0] pin_gnt_n;
  logic       pin_dmr_n;
  logic       pin_dmgi_n;
  logic       pin_dmgo_n;
  logic       pin_sack_n;
  logic       pin_sync_n;
  logic       pin_rply_n;
  logic       pin_tmo;

  // slave: the arbiter itself; master: the devices/CPU side driving it
  modport slave (
    input  pin_req_n, pin_dmgi_n, pin_sync_n, pin_rply_n,
    output pin_gnt_n, pin_dmr_n, pin_dmgo_n, pin_sack_n, pin_tmo
  );
  modport master (
    output pin_req_n, pin_dmgi_n, pin_sync_n, pin_rply_n,
    input  pin_gnt_n, pin_dmr_n, pin_dmgo_n, pin_sack_n, pin_tmo
  );
endinterface

// File: rtl/mpi_dma_arb.sv
// Four-device DMA arbiter for the MPI bus with per-grant ownership timeout.
// Define MPI_DMA_ARB_RR_EN for round-robin arbitration (default: fixed priority, index 0 highest).
module mpi_dma_arb #(
  parameter logic [7:0] GRANT_TMO = 8'd200
) (
  input  logic         pin_clk,
  input  logic         pin_dclo_n,
  mpi_dma_arb_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_ACK      = 3'd2,
    ST_WAIT_BUS = 3'd3,
    ST_OWN      = 3'd4,
    ST_REL      = 3'd5
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] req_meta_n_r, req_sync_n_r;
  logic [3:0] req_s, pend_s, mask_r;
  logic [1:0] winner_r, winner_s;
  logic [7:0] cnt_r;
  logic       tmo_hit_s;
  logic [3:0] gnt_n_r, gnt_n_s;
  logic       dmr_n_r, dmr_n_s, sack_n_r, sack_n_s, tmo_r;

  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) w = 2'(i);
    end
    return w;
  endfunction

`ifdef MPI_DMA_ARB_RR_EN
  logic [1:0] ptr_r;

  // Scan from the pointer upward with wrap; the descending loop leaves the nearest hit.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w, idx;
    w = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  assign winner_s = pick_rr(pend_s, ptr_r);
`else
  assign winner_s = pick_fixed(pend_s);
`endif

  assign req_s  = ~req_sync_n_r;
  assign pend_s = req_s & ~mask_r;

  // Two-flop synchronizer for the asynchronous device requests.
  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      req_meta_n_r <= 4'b1111;
      req_sync_n_r <= 4'b1111;
    end else begin
      req_meta_n_r <= bus.pin_req_n;
      req_sync_n_r <= req_meta_n_r;
    end
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      state_r  <= ST_IDLE;
      gnt_n_r  <= 4'b1111;
      dmr_n_r  <= 1'b1;
      sack_n_r <= 1'b1;
      tmo_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      gnt_n_r  <= gnt_n_s;
      dmr_n_r  <= dmr_n_s;
      sack_n_r <= sack_n_s;
      tmo_r    <= tmo_hit_s;
    end
  end

  // Next-state logic; withdrawal of all requests beats a simultaneous DMGI.
  always_comb begin
    state_s   = state_r;
    tmo_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|pend_s) state_s = ST_REQ;
        else         state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (~|pend_s)              state_s = ST_IDLE;
        else if (!bus.pin_dmgi_n)  state_s = ST_ACK;
        else                       state_s = ST_REQ;
      end
      ST_ACK: state_s = ST_WAIT_BUS;
      ST_WAIT_BUS: begin
        if (bus.pin_sync_n && bus.pin_rply_n) state_s = ST_OWN;
        else                                  state_s = ST_WAIT_BUS;
      end
      ST_OWN: begin
        if (!req_s[winner_r]) begin
          state_s = ST_REL;
        end else if (cnt_r == GRANT_TMO - 8'd1) begin
          state_s   = ST_REL;
          tmo_hit_s = 1'b1;
        end else begin
          state_s = ST_OWN;
        end
      end
      ST_REL:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    dmr_n_s  = 1'b1;
    sack_n_s = 1'b1;
    gnt_n_s  = 4'b1111;
    case (state_s)
      ST_REQ:                      dmr_n_s  = 1'b0;
      ST_ACK, ST_WAIT_BUS, ST_REL: sack_n_s = 1'b0;
      ST_OWN: begin
        sack_n_s = 1'b0;
        gnt_n_s  = ~(4'b0001 << winner_r);
      end
      default: begin
        dmr_n_s  = 1'b1;
        sack_n_s = 1'b1;
        gnt_n_s  = 4'b1111;
      end
    endcase
  end

  // Winner latch, ownership counter, timeout mask and round-robin pointer.
  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      winner_r <= 2'd0;
      cnt_r    <= 8'd0;
      mask_r   <= 4'b0000;
`ifdef MPI_DMA_ARB_RR_EN
      ptr_r    <= 2'd0;
`endif
    end else begin
      if (state_r == ST_REQ && state_s == ST_ACK) begin
        winner_r <= winner_s;
`ifdef MPI_DMA_ARB_RR_EN
        ptr_r    <= winner_s + 2'd1;
`endif
      end
      if (state_s == ST_OWN && state_r != ST_OWN) cnt_r <= 8'd0;
      else if (state_r == ST_OWN)                 cnt_r <= cnt_r + 8'd1;
      else                                        cnt_r <= cnt_r;
      // A masked requester is re-armed only once its request is seen idle.
      mask_r <= (mask_r & req_s) | (tmo_hit_s ? (4'b0001 << winner_r) : 4'b0000);
    end
  end

  assign bus.pin_gnt_n  = gnt_n_r;
  assign bus.pin_dmr_n  = dmr_n_r;
  assign bus.pin_sack_n = sack_n_r;
  assign bus.pin_tmo    = tmo_r;
  assign bus.pin_dmgo_n = (state_r == ST_IDLE && pin_dclo_n) ? bus.pin_dmgi_n : 1'b1;

endmodule

// File: tb/tb_mpi_dma_arb.sv
// Self-checking bench for mpi_dma_arb (GRANT_TMO = 16); expected grants are
// queued when DMGI is driven and compared when the grant appears.
module tb_mpi_dma_arb;
  logic clk;
  logic dclo_n;
  int   tests_run;
  int   tests_failed;
  logic [3:0] exp_q[$];

  mpi_dma_arb_if bus ();

  mpi_dma_arb #(.GRANT_TMO(8'd16)) dut (
    .pin_clk    (clk),
    .pin_dclo_n (dclo_n),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_dmr_low(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.pin_dmr_n === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_gnt(input logic [3:0] target, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.pin_gnt_n === target) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    dclo_n = 1'b0;
    @(negedge clk);
    dclo_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    dclo_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.pin_gnt_n, bus.pin_dmr_n, bus.pin_sack_n, bus.pin_dmgo_n, bus.pin_tmo} !== 8'b1111_1110) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b dmr=%b sack=%b dmgo=%b tmo=%b, expected 1111 1 1 1 0",
               bus.pin_gnt_n, bus.pin_dmr_n, bus.pin_sack_n, bus.pin_dmgo_n, bus.pin_tmo);
    end
    dclo_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] e;
    @(negedge clk);
    bus.pin_req_n = 4'b1110;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.pin_dmr_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL dmr_early: got %b expected 1 after 2 cycles", bus.pin_dmr_n);
    end
    @(negedge clk);
    tests_run++;
    if (bus.pin_dmr_n !== 1'b0 || bus.pin_sack_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL dmr_latency3: got dmr=%b sack=%b expected 0 1", bus.pin_dmr_n, bus.pin_sack_n);
    end
    repeat (2) @(negedge clk);
    bus.pin_dmgi_n = 1'b0;
    exp_q.push_back(4'b1110);
    @(negedge clk);
    tests_run++;
    if ({bus.pin_sack_n, bus.pin_dmr_n, bus.pin_gnt_n, bus.pin_dmgo_n} !== 7'b0_1_1111_1) begin
      tests_failed++;
      $display("FAIL ack_state: got sack=%b dmr=%b gnt=%b dmgo=%b expected 0 1 1111 1",
               bus.pin_sack_n, bus.pin_dmr_n, bus.pin_gnt_n, bus.pin_dmgo_n);
    end
    bus.pin_dmgi_n = 1'b1;
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pin_gnt_n !== e || bus.pin_tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_grant: got gnt=%b tmo=%b expected %b 0", bus.pin_gnt_n, bus.pin_tmo, e);
    end
    bus.pin_req_n = 4'b1111;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.pin_gnt_n !== 4'b1111 || bus.pin_sack_n !== 1'b0 || bus.pin_tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_rel: got gnt=%b sack=%b tmo=%b expected 1111 0 0",
               bus.pin_gnt_n, bus.pin_sack_n, bus.pin_tmo);
    end
    @(negedge clk);
    tests_run++;
    if (bus.pin_sack_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_sack: got %b expected 1", bus.pin_sack_n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    int         n;
    logic [3:0] e;
    logic [1:0] order [4];
`ifdef MPI_DMA_ARB_RR_EN
    order = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
    order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    do_reset();
    bus.pin_req_n = 4'b0000;
    for (int g = 0; g < 4; g++) begin
      wait_dmr_low(20, n);
      tests_run++;
      if (n < 0) begin
        tests_failed++;
        $display("FAIL prio_dmr_%0d: dmr_n never went low", g);
      end
      repeat (3) @(negedge clk);
      bus.pin_dmgi_n = 1'b0;
      exp_q.push_back(~(4'b0001 << order[g]));
      @(negedge clk);
      bus.pin_dmgi_n = 1'b1;
      e = exp_q.pop_front();
      wait_gnt(e, 6, n);
      tests_run++;
      if (n < 0) begin
        tests_failed++;
        $display("FAIL prio_grant_%0d: got gnt=%b expected %b", g, bus.pin_gnt_n, e);
      end
      bus.pin_req_n = 4'b0001 << order[g];
      wait_gnt(4'b1111, 10, n);
      tests_run++;
      if (n < 0) begin
        tests_failed++;
        $display("FAIL prio_release_%0d: got gnt=%b expected 1111", g, bus.pin_gnt_n);
      end
      bus.pin_req_n = 4'b0000;
    end
    bus.pin_req_n = 4'b1111;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_bus_wait();
    int         n;
    int         early;
    logic [3:0] e;
    do_reset();
    bus.pin_sync_n = 1'b0;
    bus.pin_req_n  = 4'b1101;
    wait_dmr_low(10, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL wait_dmr: dmr_n never went low");
    end
    bus.pin_dmgi_n = 1'b0;
    exp_q.push_back(4'b1101);
    @(negedge clk);
    bus.pin_dmgi_n = 1'b1;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pin_gnt_n !== 4'b1111) early++;
    end
    bus.pin_sync_n = 1'b1;
    bus.pin_rply_n = 1'b0;
    repeat (2) @(negedge clk);
    if (bus.pin_gnt_n !== 4'b1111) early++;
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL wait_bus_hold: gnt low during busy bus in %0d samples, expected 0", early);
    end
    bus.pin_rply_n = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pin_gnt_n !== e) begin
      tests_failed++;
      $display("FAIL wait_bus_grant: got %b expected %b", bus.pin_gnt_n, e);
    end
    bus.pin_req_n = 4'b1111;
    wait_gnt(4'b1111, 8, n);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    int own;
    int saw_dmr;
    bus.pin_req_n = 4'b1110;
    wait_dmr_low(10, n);
    bus.pin_dmgi_n = 1'b0;
    @(negedge clk);
    bus.pin_dmgi_n = 1'b1;
    wait_gnt(4'b1110, 6, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL tmo_grant: got gnt=%b expected 1110", bus.pin_gnt_n);
    end
    own = 1;
    while (bus.pin_gnt_n !== 4'b1111 && own < 40) begin
      @(negedge clk);
      if (bus.pin_gnt_n !== 4'b1111) own++;
    end
    tests_run++;
    if (own != 16) begin
      tests_failed++;
      $display("FAIL tmo_own_cycles: got %0d expected 16", own);
    end
    tests_run++;
    if (bus.pin_tmo !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_pulse: got %b expected 1", bus.pin_tmo);
    end
    @(negedge clk);
    tests_run++;
    if (bus.pin_tmo !== 1'b0 || bus.pin_sack_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_pulse_end: got tmo=%b sack=%b expected 0 1", bus.pin_tmo, bus.pin_sack_n);
    end
    saw_dmr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pin_dmr_n === 1'b0 || bus.pin_gnt_n !== 4'b1111) saw_dmr++;
    end
    tests_run++;
    if (saw_dmr != 0) begin
      tests_failed++;
      $display("FAIL tmo_masked: activity in %0d samples, expected 0", saw_dmr);
    end
    bus.pin_req_n = 4'b1111;
    repeat (5) @(negedge clk);
    bus.pin_req_n = 4'b1110;
    wait_dmr_low(10, n);
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL tmo_unmask: dmr latency got %0d expected 3", n);
    end
  endtask

  task automatic test_dmgo_reset();
    int         n;
    logic [3:0] pat;
    // Finish the pending request from the timeout test, then reset while owning.
    bus.pin_dmgi_n = 1'b0;
    @(negedge clk);
    bus.pin_dmgi_n = 1'b1;
    wait_gnt(4'b1110, 6, n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL regrant: got gnt=%b expected 1110", bus.pin_gnt_n);
    end
    #2;
    dclo_n = 1'b0;
    #1;
    tests_run++;
    if (bus.pin_gnt_n !== 4'b1111 || bus.pin_sack_n !== 1'b1 || bus.pin_tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got gnt=%b sack=%b tmo=%b expected 1111 1 0",
               bus.pin_gnt_n, bus.pin_sack_n, bus.pin_tmo);
    end
    bus.pin_req_n = 4'b1111;
    @(negedge clk);
    dclo_n = 1'b1;
    repeat (3) @(negedge clk);
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      bus.pin_dmgi_n = pat[i];
      #1;
      tests_run++;
      if (bus.pin_dmgo_n !== pat[i]) begin
        tests_failed++;
        $display("FAIL dmgo_follow_%0d: got %b expected %b", i, bus.pin_dmgo_n, pat[i]);
      end
      @(negedge clk);
    end
    bus.pin_dmgi_n = 1'b1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    dclo_n         = 1'b0;
    bus.pin_req_n  = 4'b1111;
    bus.pin_dmgi_n = 1'b1;
    bus.pin_sync_n = 1'b1;
    bus.pin_rply_n = 1'b1;
    test_reset();
    test_basic();
    test_priority();
    test_bus_wait();
    test_timeout();
    test_dmgo_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
